// File: rtl/ahb2_sram_slv.sv
`default_nettype none
// ============================================================================
// Module   : ahb2_sram_slv
// Purpose  : AHB2 slave backed by a word-organised RAM with programmable wait states.
// Revision : 1.0  initial release
// ============================================================================
module ahb2_sram_slv #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hreset_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hreadyi,
  output logic [31:0] hrdata,
  output logic        hreadyo,
  output logic [1:0]  hresp
);

  localparam int         c_depth    = 2 ** (ADDR_WIDTH - 2);
  localparam logic [2:0] c_cnt_init = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_LAST = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;

  logic [31:0] mem [c_depth];
  logic        accept;
  logic        can_accept;
  logic        illegal;
  logic [3:0]  byte_en;
  logic        unused_inputs;

  assign unused_inputs = ^{hburst, hprot, haddr[31:ADDR_WIDTH], htrans[0]};

  assign accept     = hsel & hreadyi & htrans[1];
  // New address phases can only overlap cycles in which this slave drives HREADY high.
  assign can_accept = (state_q == S_IDLE) || (state_q == S_LAST) || (state_q == S_ERR2);
  assign illegal    = (hsize > 3'b010) ||
                      ((hsize == 3'b001) && haddr[0]) ||
                      ((hsize == 3'b010) && (haddr[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 3'd0) state_d = S_LAST;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (can_accept && accept) begin
      addr_d  = haddr[ADDR_WIDTH-1:0];
      write_d = hwrite;
      size_d  = hsize;
      if (illegal) begin
        state_d = S_ERR1;
      end else if (WAIT_STATES == 0) begin
        state_d = S_LAST;
      end else begin
        state_d = S_WAIT;
        cnt_d   = c_cnt_init;
      end
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  always_comb begin
    byte_en = 4'b0000;
    case (size_q)
      3'b000:  byte_en = 4'b0001 << addr_q[1:0];
      3'b001:  byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
      3'b010:  byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // Commit happens on the closing edge of LAST, so a back-to-back read sees it.
  always_ff @(posedge hclk) begin
    if ((state_q == S_LAST) && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[addr_q[ADDR_WIDTH-1:2]][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  assign hreadyo = (state_q != S_WAIT) && (state_q != S_ERR1);
  assign hresp   = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
  assign hrdata  = ((state_q == S_LAST) && !write_q) ? mem[addr_q[ADDR_WIDTH-1:2]] : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_ahb2_sram_slv.sv
`default_nettype none
// Scoreboard bench for ahb2_sram_slv: instance A (WAIT_STATES=1) and B (WAIT_STATES=0)
// share one bus; a byte-level memory model predicts every response.
module tb_ahb2_sram_slv;

  logic        hclk     = 1'b0;
  logic        hreset_n = 1'b0;
  logic        hsel     = 1'b0;
  logic [31:0] haddr    = 32'h0;
  logic [1:0]  htrans   = 2'b00;
  logic        hwrite   = 1'b0;
  logic [2:0]  hsize    = 3'b000;
  logic [2:0]  hburst   = 3'b000;
  logic [3:0]  hprot    = 4'h0;
  logic [31:0] hwdata   = 32'h0;
  logic        use_b    = 1'b0;
  logic        hold     = 1'b0;
  logic        hreadyi;

  logic [31:0] hrdata_a, hrdata_b, m_rdata;
  logic        hreadyo_a, hreadyo_b, m_ready;
  logic [1:0]  hresp_a, hresp_b, m_resp;

  assign m_rdata = use_b ? hrdata_b  : hrdata_a;
  assign m_ready = use_b ? hreadyo_b : hreadyo_a;
  assign m_resp  = use_b ? hresp_b   : hresp_a;
  assign hreadyi = hold ? 1'b0 : m_ready;

  always #5 hclk = ~hclk;

  ahb2_sram_slv #(.ADDR_WIDTH(12), .WAIT_STATES(1)) dut_a (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel & ~use_b), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hreadyi(hreadyi), .hrdata(hrdata_a), .hreadyo(hreadyo_a), .hresp(hresp_a));

  ahb2_sram_slv #(.ADDR_WIDTH(12), .WAIT_STATES(0)) dut_b (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel & use_b), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hreadyi(hreadyi), .hrdata(hrdata_b), .hreadyo(hreadyo_b), .hresp(hresp_b));

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl_a [0:1023];
  logic [31:0] mdl_b [0:1023];
  logic [31:0] next_wdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge hclk);
    while (!hreadyi && n < 20) begin
      n++;
      @(negedge hclk);
    end
    if (!hreadyi) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1 at %0t", $time);
    end
  endtask

  // Address phase of one transfer; the model predicts its response from size/alignment rules.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [1:0] tr, input logic [2:0] burst);
    exp_t        e;
    logic [31:0] junk;
    logic [31:0] word;
    int          nbytes;
    int          lane;
    junk = $urandom;
    @(posedge hclk); #1;
    hwdata = next_wdata;
    hsel   = 1'b1;
    haddr  = {junk[31:12], addr[11:0]};
    hwrite = wr;
    hsize  = sz;
    htrans = tr;
    hburst = burst;
    hprot  = 4'($urandom);
    wait_ready();
    nbytes = 1 << sz;
    e.err  = (sz > 3'd2) || ((addr % nbytes) != 0);
    word   = use_b ? mdl_b[addr[11:2]] : mdl_a[addr[11:2]];
    e.data = (!wr && !e.err) ? word : 32'h0;
    if (wr && !e.err) begin
      for (int k = 0; k < nbytes; k++) begin
        lane = int'(addr[1:0]) + k;
        word[8*lane +: 8] = wd[8*lane +: 8];
      end
      if (use_b) mdl_b[addr[11:2]] = word;
      else       mdl_a[addr[11:2]] = word;
    end
    exp_q.push_back(e);
    next_wdata = wd;
  endtask

  task automatic idle_cyc(input logic sel, input logic [1:0] tr);
    @(posedge hclk); #1;
    hwdata = next_wdata;
    hsel   = sel;
    htrans = tr;
    haddr  = $urandom;
    hwrite = 1'($urandom);
    hsize  = 3'($urandom);
    wait_ready();
  endtask

  task automatic flush();
    idle_cyc(1'b0, 2'b00);
    idle_cyc(1'b0, 2'b00);
  endtask

  task automatic init_mem();
    for (int i = 0; i < 32; i++) issue(32'(i * 4), 1'b1, 3'd2, $urandom, 2'b10, 3'b000);
  endtask

  task automatic rand_ops(input int n);
    int          r;
    logic [2:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        idle_cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)));
      end else begin
        sz = (r == 2) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        a  = 32'($urandom_range(0, 127));
        issue(a, 1'($urandom_range(0, 1)), sz, $urandom,
              ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11, 3'b000);
      end
    end
  endtask

  // Monitor: tracks the data phase on the bus and compares against the queued expectation.
  bit dp    = 1'b0;
  int waits = 0;
  always @(negedge hclk) begin
    exp_t e;
    int   ws;
    ws = use_b ? 0 : 1;
    if (!hreset_n) begin
      dp    = 1'b0;
      waits = 0;
    end else begin
      if (dp) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty actual=0 required=1 at %0t", $time);
        end else begin
          e = exp_q[0];
          if (!m_ready) begin
            waits++;
            chk("wait_resp", 32'(m_resp), e.err ? 32'd1 : 32'd0);
            chk("wait_rdata", m_rdata, 32'h0);
          end else begin
            void'(exp_q.pop_front());
            chk("resp", 32'(m_resp), e.err ? 32'd1 : 32'd0);
            chk("rdata", m_rdata, e.data);
            chk("wait_cycles", 32'(waits), e.err ? 32'd1 : 32'(ws));
            waits = 0;
          end
        end
      end else begin
        chk("idle_ready", 32'(m_ready), 32'd1);
        chk("idle_resp", 32'(m_resp), 32'd0);
        chk("idle_rdata", m_rdata, 32'h0);
      end
      if (!dp || m_ready) dp = hsel & htrans[1] & hreadyi;
    end
  end

  initial begin
    repeat (3) @(posedge hclk);
    #1;
    chk("rst_ready_a", 32'(hreadyo_a), 32'd1);
    chk("rst_resp_a", 32'(hresp_a), 32'd0);
    chk("rst_rdata_a", hrdata_a, 32'h0);
    chk("rst_ready_b", 32'(hreadyo_b), 32'd1);
    hreset_n = 1'b1;

    // Instance A: one wait state
    init_mem();
    issue(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 2'b10, 3'b000);
    issue(32'h10, 1'b0, 3'd2, 32'h0, 2'b10, 3'b000);
    issue(32'h20, 1'b1, 3'd0, {4{8'h11}}, 2'b10, 3'b000);
    issue(32'h21, 1'b1, 3'd0, {4{8'h22}}, 2'b10, 3'b000);
    issue(32'h22, 1'b1, 3'd0, {4{8'h33}}, 2'b10, 3'b000);
    issue(32'h23, 1'b1, 3'd0, {4{8'h44}}, 2'b10, 3'b000);
    issue(32'h20, 1'b0, 3'd2, 32'h0, 2'b10, 3'b000);
    issue(32'h31, 1'b1, 3'd1, 32'hA5A5A5A5, 2'b10, 3'b000);
    issue(32'h30, 1'b0, 3'd2, 32'h0, 2'b10, 3'b000);
    issue(32'h40, 1'b0, 3'd3, 32'h0, 2'b10, 3'b000);
    issue(32'h44, 1'b0, 3'd2, 32'h0, 2'b10, 3'b000);
    issue(32'h22, 1'b1, 3'd1, 32'h77665544, 2'b10, 3'b000);
    issue(32'h20, 1'b0, 3'd0, 32'h0, 2'b10, 3'b000);
    rand_ops(40);
    flush();

    // Another slave holds HREADY low: a selected NONSEQ must not be taken
    @(posedge hclk); #1;
    hold = 1'b1; hsel = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b0; hsize = 3'd2;
    repeat (3) @(posedge hclk);
    #1;
    hold = 1'b0; hsel = 1'b0; htrans = 2'b00;
    flush();

    // Reset during the wait state of a write aborts it
    issue(32'h60, 1'b1, 3'd2, 32'h12345678, 2'b10, 3'b000);
    flush();
    @(posedge hclk); #1;
    hsel = 1'b1; haddr = 32'h60; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hBADC0DE0;
    chk("abort_in_wait", 32'(hreadyo_a), 32'd0);
    hreset_n = 1'b0;
    #1;
    chk("abort_ready", 32'(hreadyo_a), 32'd1);
    chk("abort_resp", 32'(hresp_a), 32'd0);
    chk("abort_rdata", hrdata_a, 32'h0);
    @(posedge hclk); #1;
    hreset_n = 1'b1;
    next_wdata = 32'h0;
    issue(32'h60, 1'b0, 3'd2, 32'h0, 2'b10, 3'b000);
    flush();

    // Instance B: zero wait states, INCR4 bursts
    use_b = 1'b1;
    init_mem();
    for (int i = 0; i < 4; i++)
      issue(32'h50 + 32'(i * 4), 1'b1, 3'd2, 32'(i + 1), (i == 0) ? 2'b10 : 2'b11, 3'b011);
    for (int i = 0; i < 4; i++)
      issue(32'h50 + 32'(i * 4), 1'b0, 3'd2, 32'h0, (i == 0) ? 2'b10 : 2'b11, 3'b011);
    issue(32'h13, 1'b1, 3'd2, 32'h0, 2'b10, 3'b000);
    issue(32'h54, 1'b0, 3'd2, 32'h0, 2'b10, 3'b000);
    rand_ops(40);
    flush();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
